fpu_operand_seq: RTL and testbench
==================================

# fpu_operand_seq

Parametrised byte-serial operand sequencer between the 8-bit tile pins and the FPU datapath. It assembles one command byte and two WIDTH-bit operands from a byte stream, then issues them to the FPU core with a valid/ready handshake. It captures the result and optional exception flags, and streams them back LSB-first on an 8-bit output channel. It generalises the fixed 32-bit pin loader to any byte-multiple width, and adds backpressure on every channel plus a clock-enable freeze.

## Interface
- WIDTH, 32, operand/result width in bits; multiple of 8, range 16..64
- OP_W, 2, opcode width in bits; range 1..7
- Derived: BYTES = WIDTH/8; counter width CW = $clog2(BYTES+1)

- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  tile enable; low freezes all state
- in_valid  in  1  input byte strobe
- in_data  in  8  input byte
- in_ready  out  1  sequencer accepts a byte this cycle
- op_valid  out  1  operands/opcode valid to FPU core
- op_ready  in  1  FPU core accepts operands
- op_a  out  WIDTH  operand A
- op_b  out  WIDTH  operand B
- op_code  out  OP_W  opcode
- res_valid  in  1  FPU result strobe
- res_data  in  WIDTH  FPU result
- res_flags  in  5  IEEE flags {NV,DZ,OF,UF,NX}
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_ready  in  1  consumer accepts output byte
- out_last  out  1  final byte of the response
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD_A, LOAD_B, ISSUE, WAIT, SEND.
- Accept = in_valid & in_ready. in_ready = ena & (state in IDLE/LOAD_A/LOAD_B).
- IDLE: an accepted byte is the command. op_code <= in_data[OP_W-1:0]; flag_en <= in_data[7]; other bits are ignored. Clear the byte counter and go to LOAD_A.
- LOAD_A: each accepted byte shifts into op_a LSB-first; byte k lands in op_a[8k+7:8k]. After BYTES accepts, clear the counter and go to LOAD_B.
- LOAD_B: same as LOAD_A for op_b. After the BYTES-th accept, go to ISSUE.
- ISSUE: op_valid = ena. op_a, op_b and op_code are held stable until op_valid & op_ready.
  - On handshake, go to WAIT.
  - If res_valid is also high in the handshake cycle (zero-latency core), capture the result then and go directly to SEND.
- WAIT: on res_valid, capture res_data and res_flags into the result shift register and go to SEND. res_valid in any other state/cycle is ignored.
- SEND: emit BYTES result bytes LSB-first, then one flag byte {3'b000, res_flags} if flag_en.
  - out_data and out_valid come from registers; the byte advances only on out_valid & out_ready.
  - out_last is high with the final byte (byte BYTES-1, or the flag byte if flag_en).
  - The handshake on the last byte returns the block to IDLE.
- ena low: no register changes. in_ready, op_valid and out_valid are forced 0. All held values resume unchanged when ena returns high.
- rst high at a clock edge, in any state, returns to IDLE regardless of ena. A partially loaded or pending transaction is discarded.
- Bytes arriving while in_ready = 0 are not consumed. The sender must hold them.

## Timing
- Reset values: state IDLE, in_ready 1 (if ena), op_valid 0, op_a 0, op_b 0, op_code 0, out_valid 0, out_data 0, out_last 0, busy 0, counters 0.
- Input: one byte per cycle at full rate. A full load takes 1+2·BYTES accept cycles.
- op_valid rises in the cycle after the last B byte is accepted.
- With a zero-latency core and op_ready = 1, the handshake occurs in that same cycle. The first out_valid appears in the next cycle.
- The first out_valid rises 1 cycle after result capture. After that, one byte per cycle while out_ready = 1.
- After the final output handshake, the next cycle is IDLE with in_ready = 1.
- Minimum turnaround, 32-bit, no flags, zero-latency core, no stalls: 9 input + 1 issue + 4 output = 14 cycles.

## Test plan
- WIDTH=32 add: send 00, 00 00 80 3F, 00 00 00 40 -> op_a=3F800000, op_b=40000000, op_code=0; op_valid exactly 1 cycle after the last byte. Model returns 40400000 -> out bytes 00 00 40 40, out_last only on the 4th.
- Flags: command 0x81, model result 7F800000 with flags 5'b00101 -> op_code=1; output 00 00 80 7F 05, out_last on the 5th byte.
- Backpressure: op_ready low 3 cycles -> op_valid and operands stable, no state change. out_ready toggled 1/0 -> each byte seen exactly once, in order, with no drop or duplicate.
- Reset mid-load: assert rst after 2 bytes of B -> next cycle busy=0, op_valid=0. A following full transaction yields correct operands with no residue from the aborted one.
- ena freeze: drop ena for 4 cycles during SEND after byte 1 -> out_valid=0 throughout; byte 2 resumes unchanged. Same check during LOAD_A: bytes presented while ena=0 are not consumed.
- WIDTH=16, OP_W=3: send 06, 00 3C, 00 40 -> op_a=3C00, op_b=4000, op_code=6. Model returns 4200 -> out bytes 00 42, out_last on the 2nd.

Source files
------------

// File: rtl/fpu_operand_seq_if.sv
// Signal bundle between the operand sequencer, the tile byte pins and the FPU core.
// master: the sequencer side; slave: the pins/core/consumer side.
interface fpu_operand_seq_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OP_W-1:0]  op_code;

    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [4:0]       res_flags;

    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  in_valid, in_data, op_ready, res_valid, res_data, res_flags, out_ready,
        output in_ready, op_valid, op_a, op_b, op_code, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, op_ready, res_valid, res_data, res_flags, out_ready,
        input  in_ready, op_valid, op_a, op_b, op_code, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fpu_operand_seq.sv
// Byte-serial operand sequencer: loads a command byte and two WIDTH-bit operands
// LSB-first, issues them to the FPU core, then streams the result (and optionally
// the exception flags) back out one byte at a time.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for the command byte
//   LOAD_A | shifting in operand A bytes
//   LOAD_B | shifting in operand B bytes
//   ISSUE  | operands presented to the FPU core, waiting for op_ready
//   WAIT   | operands taken, waiting for res_valid
//   SEND   | streaming result bytes, then the flag byte if requested
module fpu_operand_seq #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    fpu_operand_seq_if.master bus,
    output logic              busy
);
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);
    localparam logic [CW-1:0] FLAG_IDX = CW'(BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t           state;
    logic [CW-1:0]    in_cnt;
    logic [CW-1:0]    out_cnt;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [OP_W-1:0]  op_code_r;
    logic             flag_en;
    logic [WIDTH-1:0] res_sr;
    logic [4:0]       flags_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic             out_last_r;

    logic             accept;
    logic             op_fire;
    logic             out_fire;
    logic             capture;
    logic [CW-1:0]    out_nxt;

    // Handshake qualifiers; every strobe is gated by ena so a frozen tile neither
    // offers nor takes anything.
    always_comb begin
        bus.in_ready  = ena & ((state == IDLE) | (state == LOAD_A) | (state == LOAD_B));
        bus.op_valid  = ena & (state == ISSUE);
        bus.out_valid = ena & out_valid_r;
        accept        = bus.in_valid & bus.in_ready;
        op_fire       = bus.op_valid & bus.op_ready;
        out_fire      = bus.out_valid & bus.out_ready;
        // A zero-latency core answers in the issue handshake cycle itself.
        capture       = ena & bus.res_valid & ((state == WAIT) | ((state == ISSUE) & op_fire));
        out_nxt       = out_cnt + CW'(1);
    end

    assign bus.op_a     = op_a_r;
    assign bus.op_b     = op_b_r;
    assign bus.op_code  = op_code_r;
    assign bus.out_data = out_data_r;
    assign bus.out_last = out_last_r;
    assign busy         = (state != IDLE);

    // Sequencer FSM with all datapath registers; nothing moves while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_code_r   <= '0;
            flag_en     <= 1'b0;
            res_sr      <= '0;
            flags_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (ena) begin
            // Byte 0 goes straight to the output register; the rest wait in res_sr.
            if (capture) begin
                res_sr      <= bus.res_data >> 8;
                flags_r     <= bus.res_flags;
                out_data_r  <= bus.res_data[7:0];
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
                out_cnt     <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_code_r <= bus.in_data[OP_W-1:0];
                        flag_en   <= bus.in_data[7];
                        in_cnt    <= '0;
                        state     <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        // Shift right so the first byte ends up in the lowest lane.
                        op_a_r <= {bus.in_data, op_a_r[WIDTH-1:8]};
                        if (in_cnt == LAST_IDX) begin
                            in_cnt <= '0;
                            state  <= LOAD_B;
                        end else begin
                            in_cnt <= in_cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        op_b_r <= {bus.in_data, op_b_r[WIDTH-1:8]};
                        if (in_cnt == LAST_IDX) begin
                            in_cnt <= '0;
                            state  <= ISSUE;
                        end else begin
                            in_cnt <= in_cnt + CW'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (op_fire) begin
                        state <= bus.res_valid ? SEND : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.res_valid) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            out_cnt <= out_nxt;
                            if (out_nxt == FLAG_IDX) begin
                                out_data_r <= {3'b000, flags_r};
                            end else begin
                                out_data_r <= res_sr[7:0];
                                res_sr     <= res_sr >> 8;
                            end
                            out_last_r <= (out_nxt == FLAG_IDX) |
                                          ((out_nxt == LAST_IDX) & ~flag_en);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_operand_seq.sv
// Scoreboard bench for fpu_operand_seq: one 32-bit and one 16-bit instance share a
// stimulus path selected by sel16; expected operands and response bytes are queued
// when a transaction is issued and popped by a negedge monitor.
module tb_fpu_operand_seq;
    logic clk;
    logic rst;
    logic ena;
    logic sel16;

    logic        in_valid_t;
    logic [7:0]  in_data_t;
    logic        op_ready_t;
    logic        res_valid_t;
    logic [63:0] res_t;
    logic [4:0]  res_flags_t;
    logic        out_ready_t;
    logic        busy32;
    logic        busy16;

    fpu_operand_seq_if #(.WIDTH(32), .OP_W(2)) if32 ();
    fpu_operand_seq_if #(.WIDTH(16), .OP_W(3)) if16 ();

    fpu_operand_seq #(.WIDTH(32), .OP_W(2)) u32 (
        .clk (clk), .rst (rst), .ena (ena), .bus (if32), .busy (busy32)
    );
    fpu_operand_seq #(.WIDTH(16), .OP_W(3)) u16 (
        .clk (clk), .rst (rst), .ena (ena), .bus (if16), .busy (busy16)
    );

    assign if32.in_valid  = in_valid_t & ~sel16;
    assign if16.in_valid  = in_valid_t & sel16;
    assign if32.in_data   = in_data_t;
    assign if16.in_data   = in_data_t;
    assign if32.op_ready  = op_ready_t & ~sel16;
    assign if16.op_ready  = op_ready_t & sel16;
    assign if32.res_valid = res_valid_t & ~sel16;
    assign if16.res_valid = res_valid_t & sel16;
    assign if32.res_data  = res_t[31:0];
    assign if16.res_data  = res_t[15:0];
    assign if32.res_flags = res_flags_t;
    assign if16.res_flags = res_flags_t;
    assign if32.out_ready = out_ready_t & ~sel16;
    assign if16.out_ready = out_ready_t & sel16;

    wire        cur_in_ready  = sel16 ? if16.in_ready  : if32.in_ready;
    wire        cur_op_valid  = sel16 ? if16.op_valid  : if32.op_valid;
    wire        cur_out_valid = sel16 ? if16.out_valid : if32.out_valid;
    wire        cur_out_last  = sel16 ? if16.out_last  : if32.out_last;
    wire [7:0]  cur_out_data  = sel16 ? if16.out_data  : if32.out_data;
    wire        cur_busy      = sel16 ? busy16 : busy32;
    wire [63:0] cur_op_a      = sel16 ? {48'd0, if16.op_a} : {32'd0, if32.op_a};
    wire [63:0] cur_op_b      = sel16 ? {48'd0, if16.op_b} : {32'd0, if32.op_b};
    wire [6:0]  cur_op_code   = sel16 ? {4'd0, if16.op_code} : {5'd0, if32.op_code};

    typedef struct {
        logic [6:0]  code;
        logic [63:0] a;
        logic [63:0] b;
    } op_exp_t;

    op_exp_t    op_q[$];
    logic [8:0] out_q[$];

    int n_tests;
    int n_fail;
    int cyc;
    int out_hs;
    int last_out_cyc;
    int acc_cyc;
    int out_mode;
    bit rand_ena;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired before the DUT responded (t=%0t)", name, $time);
    endtask

    // Compares every presented operand set / output byte with the queue head.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!ena) begin
                chk("frozen_in_ready", cur_in_ready, 0);
                chk("frozen_op_valid", cur_op_valid, 0);
                chk("frozen_out_valid", cur_out_valid, 0);
            end
            if (cur_op_valid) begin
                if (op_q.size() == 0) begin
                    fail_now("op_unexpected");
                end else begin
                    chk("op_code", cur_op_code, op_q[0].code);
                    chk("op_a", cur_op_a, op_q[0].a);
                    chk("op_b", cur_op_b, op_q[0].b);
                    if (op_ready_t) void'(op_q.pop_front());
                end
            end
            if (cur_out_valid) begin
                if (out_q.size() == 0) begin
                    fail_now("out_unexpected");
                end else begin
                    chk("out_last_data", {cur_out_last, cur_out_data}, out_q[0]);
                    if (out_ready_t) begin
                        if (out_q[0][8]) last_out_cyc = cyc;
                        void'(out_q.pop_front());
                        out_hs++;
                    end
                end
            end
        end
    endtask

    task automatic consumer();
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       out_ready_t = 1'b1;
                1:       out_ready_t = ~out_ready_t;
                default: out_ready_t = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (rand_ena && $urandom_range(0, 5) == 0) begin
            ena        = 1'b0;
            in_valid_t = 1'b1;
            in_data_t  = b;
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
            ena = 1'b1;
        end
        in_valid_t  = 1'b1;
        in_data_t   = b;
        res_valid_t = 1'($urandom_range(0, 1));
        res_t       = {$urandom, $urandom};
        res_flags_t = 5'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            if (cur_in_ready) break;
            n++;
            if (n > 1000) begin
                fail_now("in_ready_timeout");
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid_t = 1'b0;
    endtask

    task automatic recover();
        op_q.delete();
        out_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // freeze: 0 none, 1 during LOAD_A after the first A byte, 2 during SEND after byte 0.
    task automatic txn(input logic [7:0] cmd, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [4:0] fl,
                       input int lat, input int rdly, input int freeze, input bit timing);
        int          nb;
        int          k;
        int          base;
        int          first;
        logic [63:0] wmask;
        op_exp_t     e;
        nb     = sel16 ? 2 : 4;
        wmask  = sel16 ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.code = cmd[6:0] & (sel16 ? 7'h07 : 7'h03);
        e.a    = a & wmask;
        e.b    = b & wmask;
        op_q.push_back(e);
        for (int i = 0; i < nb; i++) out_q.push_back({(i == nb - 1) && !cmd[7], res[8*i +: 8]});
        if (cmd[7]) out_q.push_back({1'b1, 3'b000, fl});
        base = out_hs;

        @(posedge clk);
        #1;
        send_byte(cmd);
        first = acc_cyc;
        for (int i = 0; i < nb; i++) begin
            send_byte(a[8*i +: 8]);
            if (freeze == 1 && i == 0) begin
                ena        = 1'b0;
                in_valid_t = 1'b1;
                in_data_t  = a[15:8];
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                ena = 1'b1;
            end
        end
        for (int i = 0; i < nb; i++) send_byte(b[8*i +: 8]);

        op_ready_t  = (rdly == 0);
        res_valid_t = (rdly == 0) && (lat == 0);
        res_t       = res;
        res_flags_t = fl;
        k = 0;
        forever begin
            @(negedge clk);
            chk("op_valid_held", cur_op_valid, 1);
            if (cur_op_valid && op_ready_t) break;
            if (k > 2000) begin
                fail_now("op_handshake_timeout");
                break;
            end
            @(posedge clk);
            #1;
            k++;
            if (k >= rdly) begin
                op_ready_t  = 1'b1;
                res_valid_t = (lat == 0);
            end
        end
        @(posedge clk);
        #1;
        op_ready_t  = 1'b0;
        res_valid_t = 1'b0;

        if (lat == 0) begin
            if (timing) begin
                @(negedge clk);
                chk("out_valid_rise", cur_out_valid, 1);
                @(posedge clk);
                #1;
            end
        end else begin
            repeat (lat - 1) begin
                @(posedge clk);
                #1;
            end
            res_valid_t = 1'b1;
            @(posedge clk);
            #1;
            res_valid_t = 1'b0;
        end

        if (freeze == 2) begin
            k = 0;
            while (out_hs < base + 1 && k < 1000) begin
                @(posedge clk);
                #1;
                k++;
            end
            ena = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            ena = 1'b1;
        end

        k = 0;
        while (out_q.size() != 0) begin
            @(negedge clk);
            k++;
            if (k > 3000) break;
        end
        if (out_q.size() != 0) begin
            fail_now("out_stream_timeout");
            recover();
        end else begin
            k = 0;
            while (cyc != last_out_cyc + 1 && k < 5) begin
                @(negedge clk);
                k++;
            end
            chk("idle_busy", cur_busy, 0);
            chk("idle_in_ready", cur_in_ready, 1);
            if (timing && lat == 0 && rdly == 0 && out_mode == 0)
                chk("turnaround", last_out_cyc - first + 1, 1 + 3 * nb + 1 + (cmd[7] ? 1 : 0));
        end
    endtask

    task automatic rand_txn();
        out_mode = $urandom_range(0, 2);
        txn(8'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        out_hs       = 0;
        last_out_cyc = -10;
        acc_cyc      = 0;
        out_mode     = 0;
        rand_ena     = 1'b0;
        sel16        = 1'b0;
        rst          = 1'b1;
        ena          = 1'b1;
        in_valid_t   = 1'b0;
        in_data_t    = 8'h00;
        op_ready_t   = 1'b0;
        res_valid_t  = 1'b0;
        res_t        = '0;
        res_flags_t  = '0;
        out_ready_t  = 1'b1;

        fork
            monitor();
            consumer();
            begin
                #2000000;
                $display("FAIL watchdog: time limit reached, got no finish, expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_op_a", if32.op_a, 0);
        chk("rst_op_b", if32.op_b, 0);
        chk("rst_op_code", if32.op_code, 0);
        chk("rst_out_valid", if32.out_valid, 0);
        chk("rst_out_data", if32.out_data, 0);
        chk("rst_out_last", if32.out_last, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_in_ready", if32.in_ready, 1);
        chk("rst_op_valid", if32.op_valid, 0);

        // 1.0 + 2.0 with zero-latency core, full rate, no stalls
        txn(8'h00, 64'h3F80_0000, 64'h4000_0000, 64'h4040_0000, 5'b00000, 0, 0, 0, 1);
        // flag byte appended
        txn(8'h81, 64'h7F00_0000, 64'h7F00_0000, 64'h7F80_0000, 5'b00101, 0, 0, 0, 1);
        // op_ready stall and toggling out_ready
        out_mode = 1;
        txn(8'h82, 64'h1122_3344, 64'h5566_7788, 64'hA1B2_C3D4, 5'b10010, 2, 3, 0, 0);
        out_mode = 0;

        // abort a load two bytes into B, with ena low at the reset edge
        @(posedge clk);
        #1;
        send_byte(8'h83);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h55); send_byte(8'hAA);
        ena = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy32, 0);
        chk("abort_op_valid", if32.op_valid, 0);
        chk("abort_in_ready", if32.in_ready, 1);
        chk("abort_op_a", if32.op_a, 0);
        txn(8'h03, 64'h1234_5678, 64'h9ABC_DEF0, 64'h0F1E_2D3C, 5'b00001, 1, 0, 0, 0);

        // ena freezes during LOAD_A and during SEND
        txn(8'h01, 64'hCAFE_F00D, 64'h0BAD_BEEF, 64'h8765_4321, 5'b00000, 0, 1, 1, 0);
        txn(8'h80, 64'h0102_0304, 64'h0506_0708, 64'h99AA_BBCC, 5'b11111, 1, 0, 2, 0);

        rand_ena = 1'b1;
        for (int t = 0; t < 25; t++) rand_txn();
        rand_ena = 1'b0;
        out_mode = 0;

        sel16 = 1'b1;
        @(negedge clk);
        chk("w16_idle_busy", busy16, 0);
        txn(8'h06, 64'h3C00, 64'h4000, 64'h4200, 5'b00000, 0, 0, 0, 1);
        txn(8'h87, 64'h7BFF, 64'h7BFF, 64'h7C00, 5'b00101, 1, 2, 0, 0);
        rand_ena = 1'b1;
        for (int t = 0; t < 12; t++) rand_txn();
        rand_ena = 1'b0;

        repeat (4) @(negedge clk);
        chk("op_queue_drained", op_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
